// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counter and sync generator for a VGA-style DAC.
// Issues pixel coordinates to an upstream pixel source. Syncs, blank and
// the returned colour are re-aligned through a PIX_LAT-deep pipeline plus
// one output register, so that the colour lines up with its coordinate.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 2,
  parameter int COLOR_W  = 10,
  parameter int CNT_W    = 12
) (
  input  logic               CLK_PIX,
  input  logic               nRst,
  input  logic               iEn,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [CNT_W-1:0]   oX,
  output logic [CNT_W-1:0]   oY,
  output logic               oReq,
  output logic               oLineStart,
  output logic               oFrameStart,
  output logic [15:0]        oFrameCnt,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK,
  output logic               VGA_SYNC,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // One beat of timing information travelling alongside the pixel request.
  typedef struct packed {
    logic hs;
    logic vs;
    logic req;
  } beat_t;

  logic             en_q;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             run;
  logic             h_last;
  logic             v_last;
  beat_t            raw;
  beat_t            dly;

  // en_q marks that iEn was already high on the previous edge: the first
  // enabled edge only arms the raster, so (0,0) is presented for exactly one
  // cycle before counting begins, both after iEn rises and after reset.
  assign run    = iEn & en_q;
  assign h_last = (hc_q == H_LAST);
  assign v_last = (vc_q == V_LAST);

  // Next state of the raster position and the completed-frame count.
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    hc_d        = hc_q;
    vc_d        = vc_q;
    frame_cnt_d = frame_cnt_q;
    if (!iEn) begin
      hc_d = '0;
      vc_d = '0;
    end else if (en_q) begin
      if (h_last) begin
        hc_d = '0;
        vc_d = v_last ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
      if (h_last && v_last) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Raster counter, frame counter and enable-history registers.
  always_ff @(posedge CLK_PIX or negedge nRst) begin
    if (!nRst) begin
      en_q        <= 1'b0;
      hc_q        <= '0;
      vc_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      en_q        <= iEn;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign oReq        = run & (hc_q < H_VIS) & (vc_q < V_VIS);
  assign oX          = oReq ? hc_q : '0;
  assign oY          = oReq ? vc_q : '0;
  assign oLineStart  = run & (hc_q == '0) & (vc_q < V_VIS);
  assign oFrameStart = run & (hc_q == '0) & (vc_q == '0);
  assign oFrameCnt   = frame_cnt_q;

  assign raw = '{hs:  run & (hc_q >= HS_BEG) & (hc_q < HS_END),
                 vs:  run & (vc_q >= VS_BEG) & (vc_q < VS_END),
                 req: oReq};

  if (PIX_LAT == 0) begin : g_no_pipe
    assign dly = raw;
  end else begin : g_pipe
    beat_t pipe_q [PIX_LAT];

    // Delay line matching the pixel source's latency.
    always_ff @(posedge CLK_PIX or negedge nRst) begin
      if (!nRst) begin
        // NOTE: the stages are cleared so syncs read inactive during reset.
        for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= raw;
        for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign dly = pipe_q[PIX_LAT-1];
  end

  logic               hs_q, vs_q, blank_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Output register: syncs, blank, and colour gated by the aligned request.
  always_ff @(posedge CLK_PIX or negedge nRst) begin
    if (!nRst) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_q    <= dly.hs;
      vs_q    <= dly.vs;
      blank_q <= dly.req;
      r_q     <= dly.req ? iRed   : '0;
      g_q     <= dly.req ? iGreen : '0;
      b_q     <= dly.req ? iBlue  : '0;
    end
  end

  assign VGA_CLK   = CLK_PIX;
  assign VGA_HS    = ~(hs_q ^ HS_POL);
  assign VGA_VS    = ~(vs_q ^ VS_POL);
  assign VGA_BLANK = blank_q;
  assign VGA_SYNC  = 1'b1;
  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Params (name, default, meaning), one per line:
  H_ACTIVE 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48.
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
  HS_POL 0, VS_POL 0: sync active level.
  PIX_LAT 2: pixel-source latency in cycles, range 0..8.
  COLOR_W 10: colour channel width.
  CNT_W 12: coordinate width.
  H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way.
REQ-002 Ports (name, direction, width, meaning), one per line:
  CLK_PIX in 1: pixel clock, the single clock.
  nRst in 1: asynchronous active-low reset.
  iEn in 1: timing run enable.
  iRed, iGreen, iBlue in COLOR_W: pixel colour, valid PIX_LAT cycles after matching oReq.
  oX, oY out CNT_W: requested coordinate.
  oReq out 1: coordinate is in the visible area.
  oLineStart out 1: one-cycle pulse at the start of a visible line.
  oFrameStart out 1: one-cycle pulse at the start of a frame.
  oFrameCnt out 16: completed-frame count.
  VGA_CLK out 1: equals CLK_PIX.
  VGA_HS, VGA_VS out 1: sync outputs.
  VGA_BLANK out 1: low = blank.
  VGA_SYNC out 1: tied 1.
  VGA_R, VGA_G, VGA_B out COLOR_W: colour outputs.

Function
REQ-003 hc counts 0..H_TOTAL-1 by 1 per cycle while iEn=1, and wraps to 0.
REQ-004 vc increments when hc wraps, and wraps to 0 after V_TOTAL-1.
REQ-005 While iEn=0, hc and vc are forced to 0 synchronously and hold there.
REQ-006 On the first edge with iEn=1, hc=vc=0 is presented; counting starts on the following edge.
REQ-007 oReq=1 iff iEn=1 and hc<H_ACTIVE and vc<V_ACTIVE; the bounds are strict.
REQ-008 oX/oY equal hc/vc when oReq=1, and 0 otherwise; both are combinational from the counters.
REQ-009 hs_raw is active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-010 vs_raw is active for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-011 hs_raw and vs_raw are never active while iEn=0.
REQ-012 hs_raw, vs_raw and oReq pass through a PIX_LAT-stage shift register, then one output register, for PIX_LAT+1 cycles total latency.
REQ-013 VGA_HS = delayed hs_raw XNOR HS_POL (output level equals HS_POL while active); VGA_VS is formed the same way with VS_POL.
REQ-014 VGA_BLANK = delayed oReq.
REQ-015 In the output register, VGA_R/G/B take iRed/iGreen/iBlue when delayed oReq=1, and 0 otherwise.
REQ-016 Corollary of REQ-015: colour sampled on a cycle maps to the coordinate requested PIX_LAT cycles earlier.
REQ-017 PIX_LAT=0: the shift register is empty; outputs are one register stage after the counters.
REQ-018 oFrameStart=1 for exactly one cycle when iEn=1 and hc=0 and vc=0.
REQ-019 oLineStart=1 when iEn=1 and hc=0 and vc<V_ACTIVE.
REQ-020 oFrameCnt increments by 1 when hc=H_TOTAL-1, vc=V_TOTAL-1 and iEn=1, and wraps 0xFFFF->0.
REQ-021 oFrameCnt holds its value while iEn=0.
REQ-022 iEn falling mid-frame: counters go to 0 on the next edge, and the pipeline drains PIX_LAT+1 cycles of already-issued data unchanged.
REQ-023 After the drain in REQ-022, outputs are blank, syncs are inactive and RGB=0.
REQ-024 CNT_W and 16-bit counters are sized so that H_TOTAL-1 and V_TOTAL-1 fit; no counter value ever reaches H_TOTAL or V_TOTAL.

Reset
REQ-025 nRst=0 asynchronously clears hc, vc, oFrameCnt and all pipeline stages.
REQ-026 During reset: VGA_HS=!HS_POL, VGA_VS=!VS_POL, VGA_BLANK=0, RGB=0, oReq=0, oLineStart=0, oFrameStart=0, oX=oY=0.
REQ-027 Reset release is sampled synchronously; the first count occurs on the second CLK_PIX edge after release with iEn=1.
REQ-028 Reset asserted mid-frame overrides iEn and every pipeline stage immediately.

Verification
REQ-029 Defaults, iEn=1, run 2 frames -> HS period 800 cycles, low for 96; VS low for exactly 2 lines (1600 cycles); frame period 420000 cycles; oFrameCnt=2.
REQ-030 PIX_LAT=2, iRed=oX[9:0] looped back through a 2-cycle delay -> when VGA_BLANK=1, VGA_R equals hc minus 3, for all 640 pixels of a line.
REQ-031 Boundary check -> oReq=1 at hc=639, vc=479; oReq=0 at hc=640 and at vc=480; oX=0 when oReq=0.
REQ-032 iEn dropped at hc=300, vc=100, then raised 50 cycles later -> after PIX_LAT+1 cycles outputs blank with syncs inactive; oFrameStart pulses on re-enable; oFrameCnt unchanged.
REQ-033 HS_POL=1, VS_POL=1 -> VGA_HS=1 only during the sync interval; during reset VGA_HS=0.
REQ-034 nRst pulsed at vc=200 -> all outputs take their reset values within the same cycle; counting restarts at (0,0).
